// File: rtl/subleq_mem_responder.sv
// Memory-side responder for the subleq core.
// It has two synchronous read/write ports with 1-cycle read latency.
// When both ports hit the same address, port 1 wins and reads see the winning write.
// A boot loader fills the RAM from a word stream before the core is released.
// Writes to LED_ADDR are mirrored onto the board LEDs.
module subleq_mem_responder #(
  parameter int WORD_SIZE = 32,
  parameter int MEM_SIZE  = 256,
  parameter int LED_ADDR  = MEM_SIZE - 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_SIZE-1:0] add1,
  input  logic [WORD_SIZE-1:0] dataIn1,
  input  logic                 write1,
  output logic [WORD_SIZE-1:0] dataOut1,
  input  logic [WORD_SIZE-1:0] add2,
  input  logic [WORD_SIZE-1:0] dataIn2,
  input  logic                 write2,
  output logic [WORD_SIZE-1:0] dataOut2,
  input  logic                 load_valid,
  input  logic [WORD_SIZE-1:0] load_data,
  input  logic                 load_last,
  output logic                 load_ready,
  output logic                 core_run,
  output logic [WORD_SIZE-1:0] led
);

  localparam int AW = $clog2(MEM_SIZE);

  typedef enum logic {ST_LOAD, ST_RUN} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic [WORD_SIZE-1:0] dout1_q, dout1_d;
  logic [WORD_SIZE-1:0] dout2_q, dout2_d;
  logic [WORD_SIZE-1:0] led_q, led_d;
  logic                 load_ready_q, load_ready_d;
  logic                 core_run_q, core_run_d;

  logic [WORD_SIZE-1:0] mem [MEM_SIZE];

  logic                 in1, in2, run, accept, hit1, hit2;
  logic [AW-1:0]        idx1, idx2;
  logic                 we_a, we_b;
  logic [AW-1:0]        wa_a, wa_b;
  logic [WORD_SIZE-1:0] wd_a, wd_b;

  // Decode the ports, arbitrate the writes, and compute the next state, read data and LED value.
  // Write port A is shared by the boot loader and core port 1, because they are never active together.
  always_comb begin
    run    = (state_q == ST_RUN);
    in1    = (add1 < WORD_SIZE'(MEM_SIZE));
    in2    = (add2 < WORD_SIZE'(MEM_SIZE));
    idx1   = add1[AW-1:0];
    idx2   = add2[AW-1:0];
    accept = (state_q == ST_LOAD) && load_ready_q && load_valid;
    hit1   = run && write1 && in1;
    hit2   = run && write2 && in2 && !(hit1 && (idx1 == idx2));

    we_a = accept || hit1;
    wa_a = accept ? ptr_q : idx1;
    wd_a = accept ? load_data : dataIn1;
    we_b = hit2;
    wa_b = idx2;
    wd_b = dataIn2;

    state_d = state_q;
    ptr_d   = ptr_q;
    if (accept) begin
      if (load_last || (ptr_q == AW'(MEM_SIZE - 1))) begin
        state_d = ST_RUN;
      end else begin
        ptr_d = ptr_q + AW'(1);
      end
    end
    load_ready_d = (state_d == ST_LOAD);
    core_run_d   = (state_d == ST_RUN);

    dout1_d = '0;
    if (run && in1) begin
      if (hit1 && (idx1 == idx1)) begin
        dout1_d = dataIn1;
      end else begin
        dout1_d = mem[idx1];
      end
      if (hit2 && (idx2 == idx1)) begin
        dout1_d = dataIn2;
      end
    end

    dout2_d = '0;
    if (run && in2) begin
      if (hit1 && (idx1 == idx2)) begin
        dout2_d = dataIn1;
      end else if (hit2) begin
        dout2_d = dataIn2;
      end else begin
        dout2_d = mem[idx2];
      end
    end

    led_d = led_q;
    if (we_b && (wa_b == AW'(LED_ADDR))) begin
      led_d = wd_b;
    end
    if (we_a && (wa_a == AW'(LED_ADDR))) begin
      led_d = wd_a;
    end
  end

  // The RAM array is not reset, so that booted contents stay independent of the control state.
  always_ff @(posedge clk) begin
    if (we_a) begin
      mem[wa_a] <= wd_a;
    end
    if (we_b) begin
      mem[wa_b] <= wd_b;
    end
  end

  // Control, read-data and LED registers, which are all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      ptr_q        <= '0;
      dout1_q      <= '0;
      dout2_q      <= '0;
      led_q        <= '0;
      load_ready_q <= 1'b0;
      core_run_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      dout1_q      <= dout1_d;
      dout2_q      <= dout2_d;
      led_q        <= led_d;
      load_ready_q <= load_ready_d;
      core_run_q   <= core_run_d;
    end
  end

  assign dataOut1   = dout1_q;
  assign dataOut2   = dout2_q;
  assign led        = led_q;
  assign load_ready = load_ready_q;
  assign core_run   = core_run_q;

endmodule
